// File: rtl/uart_tx_word_seq.sv
// Word-to-byte sequencer in front of a byte-wide UART transmitter.
// A captured word is sent one byte at a time. Each byte waits for the
// transmitter's done pulse, with an optional idle gap before the next byte
// and a timeout that abandons the word. All outputs are registered.
module uart_tx_word_seq #(
    parameter int SIZE_DATA      = 8,
    parameter int NUM_BYTES      = 4,
    parameter bit MSB_FIRST      = 1'b1,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    input  logic [SIZE_DATA*NUM_BYTES-1:0] i_word,
    output logic                           o_ready,
    output logic                           o_tx_en,
    output logic [SIZE_DATA-1:0]           o_tx_data,
    input  logic                           i_tx_done,
    output logic                           o_busy,
    output logic                           o_word_done,
    output logic                           o_error
);

    localparam int W       = SIZE_DATA * NUM_BYTES;
    localparam int IDX_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

    state_t           state, nstate;
    logic [IDX_W-1:0] idx, nidx;
    logic [CNT_W-1:0] cnt, ncnt;
    logic [W-1:0]     word_q, nword;
    logic             word_done_d, error_d;

    // Byte idx of a word in transmit order; idx 0 is the first byte on the wire.
    function automatic logic [SIZE_DATA-1:0] pick(input logic [W-1:0] w,
                                                  input logic [IDX_W-1:0] i);
        logic [W-1:0] sh;
        if (MSB_FIRST) sh = w >> (SIZE_DATA * (NUM_BYTES - 1 - int'(i)));
        else           sh = w >> (SIZE_DATA * int'(i));
        return sh[SIZE_DATA-1:0];
    endfunction

    // Next-state logic. A single counter serves both the wait timeout and the gap,
    // because the two states never overlap. It is cleared on entry to each state.
    always_comb begin
        nstate      = state;
        nidx        = idx;
        ncnt        = cnt;
        nword       = word_q;
        word_done_d = 1'b0;
        error_d     = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    nword  = i_word;
                    nidx   = '0;
                    nstate = SEND;
                end
            end
            SEND: begin
                ncnt   = '0;
                nstate = WAIT;
            end
            WAIT: begin
                // done wins over a timeout that expires in the same cycle
                if (i_tx_done) begin
                    ncnt = '0;
                    if (idx == IDX_LAST) begin
                        nstate      = IDLE;
                        word_done_d = 1'b1;
                    end else begin
                        nidx   = idx + IDX_W'(1);
                        nstate = (GAP_CYCLES == 0) ? SEND : GAP;
                    end
                end else if (cnt == TO_LAST) begin
                    nstate  = IDLE;
                    error_d = 1'b1;
                end else begin
                    ncnt = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) nstate = SEND;
                else                 ncnt   = cnt + CNT_W'(1);
            end
            default: nstate = IDLE;
        endcase
    end

    // State, byte index, counter and captured word registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            word_q <= '0;
        end else begin
            state  <= nstate;
            idx    <= nidx;
            cnt    <= ncnt;
            word_q <= nword;
        end
    end

    // Outputs are registered from the next state, so each one lines up with the state it describes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ready     <= 1'b0;
            o_busy      <= 1'b0;
            o_tx_en     <= 1'b0;
            o_tx_data   <= '0;
            o_word_done <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            o_ready     <= (nstate == IDLE);
            o_busy      <= (nstate != IDLE);
            o_tx_en     <= (nstate == SEND);
            o_word_done <= word_done_d;
            o_error     <= error_d;
            if (nstate == SEND) o_tx_data <= pick(nword, nidx);
        end
    end

endmodule

// File: tb/tb_uart_tx_word_seq.sv
// Bench for uart_tx_word_seq. There are two instances: one is MSB-first with a gap of 16,
// the other is LSB-first with no gap. The bench acts as the UART transmitter and predicts
// every output cycle by cycle from the word, the done delays and the gap/timeout rules.
module tb_uart_tx_word_seq;

    localparam int TO = 100;

    logic        clk = 1'b0, rst_n = 1'b0, sel = 1'b0, valid = 1'b0, done = 1'b0;
    logic [31:0] word = '0;

    logic       ready0, en0, busy0, wd0, err0;
    logic       ready1, en1, busy1, wd1, err1;
    logic [7:0] data0, data1;
    logic       ready, en, busy, wd, err;
    logic [7:0] data;

    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    uart_tx_word_seq #(.SIZE_DATA(8), .NUM_BYTES(4), .MSB_FIRST(1'b1),
                       .GAP_CYCLES(16), .TIMEOUT_CYCLES(TO)) u_dut_msb (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid & ~sel), .i_word(word),
        .o_ready(ready0), .o_tx_en(en0), .o_tx_data(data0), .i_tx_done(done & ~sel),
        .o_busy(busy0), .o_word_done(wd0), .o_error(err0));

    uart_tx_word_seq #(.SIZE_DATA(8), .NUM_BYTES(4), .MSB_FIRST(1'b0),
                       .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) u_dut_lsb (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid & sel), .i_word(word),
        .o_ready(ready1), .o_tx_en(en1), .o_tx_data(data1), .i_tx_done(done & sel),
        .o_busy(busy1), .o_word_done(wd1), .o_error(err1));

    assign ready = sel ? ready1 : ready0;
    assign en    = sel ? en1    : en0;
    assign data  = sel ? data1  : data0;
    assign busy  = sel ? busy1  : busy0;
    assign wd    = sel ? wd1    : wd0;
    assign err   = sel ? err1   : err0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // k-th byte on the wire for a given order
    function automatic logic [7:0] exp_byte(input logic [31:0] w, input bit lsb_first, input int k);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = 8'((w >> (8 * i)) & 32'hFF);
        return lsb_first ? b[k] : b[3 - k];
    endfunction

    // One word, end to end. Cycle 1 is the first cycle after capture. Each byte is answered
    // dly cycles after its tx_en; byte stall_idx uses stall_dly instead. A delay above TO
    // means that byte times out. spur adds ignored done pulses and random valid/word while busy.
    task automatic run_word(input bit s, input logic [31:0] w, input int dly,
                            input int stall_idx, input int stall_dly, input bit spur,
                            input bit hold, input bit started, input logic [31:0] nxt);
        int gap = s ? 0 : 16;
        int exp_en = 1, sched = -1, wd_exp = -1, err_exp = -1, en_cyc = -1;
        int nb = 0, k = 0, d = 0;
        logic [7:0] cur = '0;
        bit fin = 1'b0;
        sel = s;
        if (!started) begin
            int i = 0;
            do begin
                @(negedge clk); valid = 1'b0; done = 1'b0; i++;
            end while (!ready && i < 200);
            chk("ready_before_word", ready, 1);
            valid = 1'b1; word = w;
        end
        for (int cyc = 1; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            chk("tx_en", en, cyc == exp_en);
            chk("word_done", wd, cyc == wd_exp);
            chk("error", err, cyc == err_exp);
            fin = (cyc == wd_exp) || (cyc == err_exp);
            chk("busy", busy, !fin);
            chk("ready", ready, fin);
            if (cyc == exp_en) begin
                cur = exp_byte(w, s, nb);
                chk("tx_data", data, cur);
                k = nb; nb++; en_cyc = cyc; exp_en = -1;
                d = (k == stall_idx) ? stall_dly : dly;
                sched = cyc + d;
                if (d > TO) err_exp = cyc + TO + 1;
            end else if (!fin) begin
                chk("tx_data_hold", data, cur);
            end
            done  = 1'b0;
            valid = hold || (spur && !fin && ($urandom_range(1) != 0));
            word  = $urandom;
            if (cyc == sched) begin
                done = 1'b1;
                if (cyc - en_cyc <= TO) begin
                    if (k == 3) wd_exp = cyc + 1;
                    else        exp_en = cyc + gap + 1;
                end
            end else if (spur && (cyc == en_cyc || (gap > 0 && exp_en > 0 && cyc == exp_en - 2))) begin
                done = 1'b1;
            end
            if (fin && hold) word = nxt;
        end
        chk("word_finished", fin, 1);
    endtask

    // Reset is asserted during the gap after the second byte's done.
    task automatic reset_in_gap();
        int ndone = 0, t_done = -1;
        sel = 1'b0;
        @(negedge clk); valid = 1'b1; word = 32'hCAFEBABE;
        for (int cyc = 1; cyc < 500 && ndone < 2; cyc++) begin
            @(negedge clk); valid = 1'b0; done = 1'b0;
            if (en) t_done = cyc + 5;
            if (cyc == t_done) begin done = 1'b1; ndone++; end
        end
        chk("rst_setup_dones", ndone, 2);
        @(negedge clk); done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gap_busy", busy, 1);
        rst_n = 1'b0; #1;
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_en", en, 0);
        chk("rst_tx_data", data, 0);
        chk("rst_word_done", wd, 0);
        chk("rst_error", err, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_release", ready, 1);
        run_word(0, 32'h12345678, 7, -1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            chk("reset_ready", ready, 0);
            chk("reset_busy", busy, 0);
            chk("reset_tx_en", en, 0);
            chk("reset_tx_data", data, 0);
            chk("reset_word_done", wd, 0);
            chk("reset_error", err, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset_msb", ready1 ? ready0 : 1'b0, 1);
        chk("ready_after_reset_lsb", ready1, 1);

        // spurious done while idle must not start anything
        sel = 1'b0; done = 1'b1;
        @(negedge clk); done = 1'b0;
        chk("idle_spur_busy", busy, 0);
        chk("idle_spur_tx_en", en, 0);

        run_word(0, 32'h3F800000, 20, -1, 0, 0, 0, 0, 0);
        run_word(1, 32'h40490FDB, 20, -1, 0, 0, 0, 0, 0);
        run_word(0, 32'hA5C3E10F, 4, -1, 0, 1, 0, 0, 0);
        run_word(1, 32'h0BADF00D, 3, -1, 0, 1, 0, 0, 0);
        run_word(0, 32'h11223344, 20, 0, 1000, 0, 0, 0, 0);
        run_word(0, 32'h55667788, 6, 2, TO, 0, 0, 0, 0);
        run_word(1, 32'h99AABBCC, 5, 1, TO + 1, 0, 0, 0, 0);
        run_word(0, 32'hDEADBEEF, 3, -1, 0, 0, 1, 0, 32'h01020304);
        run_word(0, 32'h01020304, 2, -1, 0, 1, 0, 1, 0);
        run_word(1, 32'hFEEDFACE, 1, -1, 0, 0, 1, 0, 32'h76543210);
        run_word(1, 32'h76543210, 1, -1, 0, 0, 0, 1, 0);
        reset_in_gap();

        for (int i = 0; i < 10; i++) begin
            run_word($urandom_range(1) != 0, $urandom, $urandom_range(30, 1), -1, 0,
                     $urandom_range(1) != 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_word_seq.md
UART_TX_WORD_SEQ -- requirements
Module: uart_tx_word_seq

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 8, byte width sent to the UART transmitter.
REQ-002 SHALL have parameter NUM_BYTES, default 4, bytes per word (word width = SIZE_DATA*NUM_BYTES).
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 = most significant byte sent first, 0 = least significant byte first.
REQ-004 SHALL have parameter GAP_CYCLES, default 16, idle clocks between a byte's done and the next byte's enable (0 allowed).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum clocks to wait for a byte done.
REQ-006 i_clk  input  1  single clock; all state on rising edge.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_valid  input  1  word request from producer (FPU result path).
REQ-009 i_word  input  SIZE_DATA*NUM_BYTES  word to transmit.
REQ-010 o_ready  output  1  sequencer can accept a word.
REQ-011 o_tx_en  output  1  one-cycle start strobe to the UART transmitter.
REQ-012 o_tx_data  output  SIZE_DATA  byte presented to the UART transmitter.
REQ-013 i_tx_done  input  1  one-cycle pulse from the transmitter when a byte's stop bit completes.
REQ-014 o_busy  output  1  high while a word is in progress.
REQ-015 o_word_done  output  1  one-cycle pulse after the last byte's done.
REQ-016 o_error  output  1  one-cycle pulse on byte timeout.

Function
REQ-017 SHALL implement states IDLE, SEND, WAIT, GAP.
REQ-018 IDLE: o_ready=1; on i_valid=1 SHALL capture i_word into an internal register, clear byte index to 0, go to SEND next cycle.
REQ-019 SEND: SHALL assert o_tx_en for exactly one cycle with o_tx_data = byte[index], then go to WAIT.
REQ-020 Byte selection: MSB_FIRST=1 -> index 0 is bits [W-1 -: SIZE_DATA]; MSB_FIRST=0 -> index 0 is bits [SIZE_DATA-1:0].
REQ-021 o_tx_data SHALL hold the current byte value from SEND until the next SEND or return to IDLE.
REQ-022 WAIT: on i_tx_done=1, if index = NUM_BYTES-1 SHALL pulse o_word_done next cycle and go to IDLE; else increment index and go to GAP (or directly to SEND when GAP_CYCLES=0).
REQ-023 GAP: SHALL count GAP_CYCLES clocks, then go to SEND; second byte's o_tx_en therefore occurs GAP_CYCLES+1 cycles after the i_tx_done cycle.
REQ-024 WAIT timeout counter SHALL restart on entry to WAIT; if TIMEOUT_CYCLES clocks elapse without i_tx_done, SHALL pulse o_error, abandon the word (no o_word_done), go to IDLE.
REQ-025 i_tx_done in the same cycle the timeout expires SHALL count as done (no error).
REQ-026 i_tx_done outside WAIT (including the SEND cycle) SHALL be ignored.
REQ-027 o_ready=0 in SEND/WAIT/GAP; i_valid there SHALL be ignored and i_word not sampled.
REQ-028 o_busy SHALL be 1 in SEND, WAIT, GAP; 0 in IDLE.
REQ-029 Back-to-back: i_valid held high SHALL start the next word the cycle after returning to IDLE (o_word_done cycle = o_ready cycle).
REQ-030 All outputs SHALL be registered; no combinational path from i_valid or i_tx_done to any output.

Reset
REQ-031 On i_rst_n=0, asynchronously: state=IDLE, index=0, counters=0, word register=0, o_tx_en=0, o_tx_data=0, o_busy=0, o_word_done=0, o_error=0, o_ready=0 while reset asserted, 1 on first clock after release.
REQ-032 Reset mid-word SHALL abort without o_word_done or o_error; first post-reset i_valid starts a fresh word at index 0.

Verification
REQ-033 MSB_FIRST=1, i_word=0x3F800000, done pulse 20 cycles after each tx_en -> o_tx_data 0x3F,0x80,0x00,0x00 in order, one o_word_done.
REQ-034 MSB_FIRST=0, i_word=0x40490FDB -> bytes 0xDB,0x0F,0x49,0x40.
REQ-035 GAP_CYCLES=16 -> each next o_tx_en exactly 17 cycles after prior i_tx_done; GAP_CYCLES=0 -> 1 cycle.
REQ-036 TIMEOUT_CYCLES=100, withhold i_tx_done after byte 1 -> o_error pulse at wait cycle 100, no o_word_done, o_ready=1 next cycle.
REQ-037 Reset asserted during GAP after byte 2 -> all outputs zero immediately; new word 0x12345678 after release sends 0x12 first.
REQ-038 Spurious i_tx_done in IDLE/GAP and i_valid while busy -> no state change, captured word unchanged.
